// File: rtl/systolic_acc_collector_pkg.sv
// Shared definitions for the systolic accumulator collector: FSM state
// encoding and the accumulator-width helper.
package systolic_acc_collector_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    SNAP  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Accumulator width is twice the PE operand width.
  function automatic int acc_w(input int width);
    return 2 * width;
  endfunction

endpackage

// File: rtl/systolic_acc_collector.sv
// Collects one systolic column of PE accumulators per job. A baseline of the
// PE accumulators is taken at start, the column is snapshotted after the
// MAC steps plus skew have elapsed, and the per-lane deltas are streamed out
// one word per valid/ready handshake.
module systolic_acc_collector
  import systolic_acc_collector_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N     = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_start,
  input  logic [7:0]                     i_k_len,
  input  logic [N*acc_w(WIDTH)-1:0]      i_mac,
  input  logic                           i_ready,
  output logic [acc_w(WIDTH)-1:0]        o_data,
  output logic                           o_valid,
  output logic                           o_last,
  output logic                           o_busy,
  output logic                           o_done
);

  localparam int ACC_W = acc_w(WIDTH);
  // Wide enough for 255 MAC steps plus the column skew.
  localparam int CNT_W = $clog2(256 + N) + 1;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  state_t               r_state;
  state_t               w_next_state;
  // i_k_len is captured as the RUN length (k + N) in the wait counter.
  logic [CNT_W-1:0]     r_wait_cnt;
  logic [IDX_W-1:0]     r_idx;
  logic [ACC_W-1:0]     r_base   [N];
  logic [ACC_W-1:0]     r_result [N];
  logic [ACC_W-1:0]     w_lane   [N];
  logic [ACC_W-1:0]     w_diff   [N];
  logic [IDX_W-1:0]     w_idx_nxt;
  logic                 w_hs;
  logic                 w_idx_last;

  assign w_hs       = o_valid & i_ready;
  assign w_idx_last = (r_idx == IDX_W'(N - 1));
  assign w_idx_nxt  = r_idx + IDX_W'(1);

  // Split the packed PE bus into lanes and form the modular per-lane delta.
  always_comb begin
    for (int j = 0; j < N; j++) begin
      w_lane[j] = i_mac[j*ACC_W +: ACC_W];
      w_diff[j] = w_lane[j] - r_base[j];
    end
  end

  // Next-state decode.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (i_start) w_next_state = RUN; else w_next_state = IDLE;
      RUN:     if (r_wait_cnt == CNT_W'(1)) w_next_state = SNAP; else w_next_state = RUN;
      SNAP:    w_next_state = DRAIN;
      DRAIN:   if (w_hs && w_idx_last) w_next_state = IDLE; else w_next_state = DRAIN;
      default: w_next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // Wait counter, baseline capture, result snapshot and drain index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt <= '0;
      r_idx      <= '0;
      for (int j = 0; j < N; j++) begin
        r_base[j]   <= '0;
        r_result[j] <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_wait_cnt <= CNT_W'(i_k_len) + CNT_W'(N);
            for (int j = 0; j < N; j++) r_base[j] <= w_lane[j];
          end
        end
        RUN:  r_wait_cnt <= r_wait_cnt - CNT_W'(1);
        SNAP: begin
          r_idx <= '0;
          for (int j = 0; j < N; j++) r_result[j] <= w_diff[j];
        end
        DRAIN: begin
          if (w_hs && !w_idx_last) r_idx <= w_idx_nxt;
        end
        default: r_idx <= '0;
      endcase
    end
  end

  // Registered stream outputs and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_data  <= '0;
      o_valid <= 1'b0;
      o_last  <= 1'b0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      o_busy <= (w_next_state != IDLE);
      o_done <= (r_state == DRAIN) && w_hs && w_idx_last;
      case (r_state)
        SNAP: begin
          // Lane 0 comes straight from the delta being stored this edge.
          o_data  <= w_diff[0];
          o_valid <= 1'b1;
          o_last  <= (N == 1);
        end
        DRAIN: begin
          if (w_hs && w_idx_last) begin
            o_valid <= 1'b0;
            o_last  <= 1'b0;
          end else if (w_hs) begin
            o_data <= r_result[w_idx_nxt];
            o_last <= (w_idx_nxt == IDX_W'(N - 1));
          end else begin
            o_data <= o_data;
          end
        end
        default: begin
          o_valid <= 1'b0;
          o_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_acc_collector.sv
// Directed bench for systolic_acc_collector (WIDTH=8, N=4).
module tb_systolic_acc_collector;

  localparam int WIDTH = 8;
  localparam int N     = 4;
  localparam int AW    = 2 * WIDTH;

  logic            clk = 1'b0;
  logic            rst;
  logic            i_start;
  logic [7:0]      i_k_len;
  logic [N*AW-1:0] i_mac;
  logic            i_ready;
  logic [AW-1:0]   o_data;
  logic            o_valid, o_last, o_busy, o_done;

  int n_checks = 0;
  int n_fail   = 0;

  systolic_acc_collector #(.WIDTH(WIDTH), .N(N)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_k_len(i_k_len),
    .i_mac(i_mac), .i_ready(i_ready), .o_data(o_data), .o_valid(o_valid),
    .o_last(o_last), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N*AW-1:0] base;
    logic [N*AW-1:0] fin;
    logic [7:0]      k;
    logic [N*AW-1:0] exp;
    string           name;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Pulse start with baseline on i_mac; returns at the negedge after the start edge.
  task automatic start_job(input logic [N*AW-1:0] base, input logic [7:0] k);
    i_mac   = base;
    i_k_len = k;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  // Waits (bounded) for o_valid; lat is the number of cycles waited.
  task automatic wait_valid(input string name, output int lat);
    lat = 0;
    while (!o_valid && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    if (!o_valid) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  // Accepts N words, optional 3-cycle stall on one word; returns at the o_done negedge.
  task automatic drain_check(input string name, input logic [N*AW-1:0] exp, input int stall_word);
    for (int j = 0; j < N; j++) begin
      if (j == stall_word) begin
        i_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          check({name, "_stall_valid"}, 32'(o_valid), 32'd1);
          check({name, "_stall_data"}, 32'(o_data), 32'(exp[j*AW +: AW]));
          check({name, "_stall_last"}, 32'(o_last), 32'(j == N - 1));
          @(negedge clk);
        end
        i_ready = 1'b1;
      end
      check({name, "_valid"}, 32'(o_valid), 32'd1);
      check({name, "_data"}, 32'(o_data), 32'(exp[j*AW +: AW]));
      check({name, "_last"}, 32'(o_last), 32'(j == N - 1));
      check({name, "_done_low"}, 32'(o_done), 32'd0);
      @(negedge clk);
    end
    check({name, "_done"}, 32'(o_done), 32'd1);
    check({name, "_valid_off"}, 32'(o_valid), 32'd0);
    check({name, "_busy_off"}, 32'(o_busy), 32'd0);
  endtask

  // Full job: start, feed final PE values, check latency and drained words.
  task automatic run_job(input vec_t v, input int stall_word);
    int lat;
    start_job(v.base, v.k);
    check({v.name, "_busy"}, 32'(o_busy), 32'd1);
    i_mac = v.fin;
    wait_valid(v.name, lat);
    check({v.name, "_latency"}, 32'(lat), 32'(v.k) + 32'(N) + 32'd1);
    drain_check(v.name, v.exp, stall_word);
  endtask

  initial begin
    int lat;
    vecs[0] = '{{4{16'd0}},    {4{16'd30}},  8'd5, {4{16'd30}},   "basic"};
    vecs[1] = '{{4{16'd100}},  {4{16'd150}}, 8'd5, {4{16'd50}},   "baseline"};
    vecs[2] = '{{4{16'hFFF0}}, {4{16'h0010}}, 8'd3, {4{16'h0020}}, "wrap"};
    vecs[3] = '{{16'd4, 16'd3, 16'd2, 16'd1}, {16'd44, 16'd33, 16'd22, 16'd11},
                8'd0, {16'd40, 16'd30, 16'd20, 16'd10}, "k_zero"};
    vecs[4] = '{{16'h1234, 16'hFFFF, 16'h0001, 16'h8000},
                {16'h1234, 16'h0000, 16'h0000, 16'h7FFF}, 8'd2,
                {16'h0000, 16'h0001, 16'hFFFF, 16'hFFFF}, "lanes_wrap"};
    vecs[5] = '{{4{16'd0}}, {16'd4, 16'd3, 16'd2, 16'd1}, 8'd255,
                {16'd4, 16'd3, 16'd2, 16'd1}, "k_max"};

    rst = 1'b1; i_start = 1'b0; i_k_len = 8'd0; i_mac = '0; i_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_data", 32'(o_data), 32'd0);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_last", 32'(o_last), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run_job(vecs[i], -1);
      @(negedge clk);
      check({vecs[i].name, "_done_pulse"}, 32'(o_done), 32'd0);
    end

    // Backpressure on word 2.
    run_job('{{4{16'd0}}, {16'd8, 16'd7, 16'd6, 16'd5}, 8'd1,
              {16'd8, 16'd7, 16'd6, 16'd5}, "bp"}, 2);
    @(negedge clk);

    // Start during RUN must not re-baseline or restart the counter.
    start_job({4{16'd10}}, 8'd4);
    i_mac = {4{16'd25}};
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    wait_valid("run_start", lat);
    check("run_start_latency", 32'(lat + 2), 32'd9);
    drain_check("run_start", {4{16'd15}}, -1);
    @(negedge clk);

    // Reset in the middle of DRAIN, then restart on the first edge after release.
    start_job({4{16'd0}}, 8'd2);
    i_mac = {16'd4, 16'd3, 16'd2, 16'd1};
    wait_valid("mid_rst", lat);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(o_valid), 32'd0);
    check("mid_rst_data", 32'(o_data), 32'd0);
    check("mid_rst_last", 32'(o_last), 32'd0);
    check("mid_rst_busy", 32'(o_busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_job('{{4{16'd7}}, {4{16'd19}}, 8'd1, {4{16'd12}}, "after_rst"}, -1);

    // Back-to-back: second start issued in the o_done cycle.
    run_job('{{4{16'd0}}, {16'd9, 16'd9, 16'd9, 16'd9}, 8'd0, {4{16'd9}}, "b2b_first"}, -1);
    run_job('{{4{16'd5}}, {16'd6, 16'd7, 16'd8, 16'd9}, 8'd3,
              {16'd1, 16'd2, 16'd3, 16'd4}, "b2b_second"}, -1);
    @(negedge clk);
    check("final_idle_busy", 32'(o_busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/systolic_acc_collector.md
SYSTOLIC_ACC_COLLECTOR -- requirements
Module: systolic_acc_collector

Interface
REQ-001 SHALL have parameter WIDTH, default 8: PE operand width; accumulator width is 2*WIDTH.
REQ-002 SHALL have parameter N, default 4: number of PE accumulators (one systolic column) collected per job.
REQ-003 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port i_start, input, 1 bit: job start pulse.
REQ-006 SHALL have port i_k_len, input, 8 bits: MAC steps per job.
REQ-007 SHALL have port i_mac, input, N*2*WIDTH bits: packed PE accumulator outputs; lane j is bits [j*2*WIDTH +: 2*WIDTH].
REQ-008 SHALL have port i_ready, input, 1 bit: downstream ready.
REQ-009 SHALL have port o_data, output, 2*WIDTH bits: one result word per handshake.
REQ-010 SHALL have port o_valid, output, 1 bit: o_data valid.
REQ-011 SHALL have port o_last, output, 1 bit: marks lane N-1.
REQ-012 SHALL have port o_busy, output, 1 bit: high in any state other than IDLE.
REQ-013 SHALL have port o_done, output, 1 bit: one-cycle pulse after the last word is accepted.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, SNAP, DRAIN.
REQ-015 SHALL move IDLE->RUN on a clk edge with i_start=1, capture every i_mac lane into a baseline register, latch i_k_len, and load wait counter to i_k_len+N.
- i_start outside IDLE is ignored with no side effect.
REQ-016 SHALL decrement the wait counter once per cycle in RUN and move to SNAP on the edge where the counter equals 1.
- RUN lasts exactly i_k_len+N cycles, covering the systolic skew plus the PE output register.
REQ-017 SHALL in SNAP, for every lane j, store result[j] = i_mac[j] - baseline[j] modulo 2^(2*WIDTH), then enter DRAIN with lane index 0.
- Wrap-around of the PE accumulator is handled by the modular subtraction.
REQ-018 SHALL in DRAIN drive o_valid=1 and o_data=result[index], and set o_last=1 only when index=N-1.
REQ-019 SHALL advance index only when o_valid and i_ready are both 1.
- o_data is held stable while i_ready=0.
- o_valid, once asserted, is not withdrawn before the handshake.
REQ-020 SHALL, on the handshake with index=N-1, go to IDLE and assert o_done for exactly the next cycle.
- A start in that cycle is accepted (back-to-back jobs).
REQ-021 SHALL treat i_k_len=0 as valid: RUN lasts N cycles and the results reflect whatever the PEs accumulated.
REQ-022 SHALL register all outputs; no combinational path from any input to any output.
REQ-023 SHALL keep o_valid=0 and o_last=0 outside DRAIN.

Reset
REQ-024 SHALL, while rst=1, immediately force state IDLE and clear to zero: counter, index, baseline, results, o_data, o_valid, o_last, o_busy, o_done.
REQ-025 SHALL abort any job that is in progress when rst asserts, with no partial output after release.
REQ-026 SHALL accept i_start on the first clk edge after rst deasserts.

Structure
REQ-027 SHALL place the FSM state enum typedef and the ACC_W = 2*WIDTH helper in the shared definition package.
REQ-028 SHALL implement the wait counter, index and result buffer inline.
- No sub-module is required.
- The buffer SHALL be an N-entry register array, not inferred memory.

Verification
REQ-029 Basic job, WIDTH=8, N=4: baseline lanes 0; PEs fed constant 2*3 for k=5 steps; i_ready=1 -> four words of value 30, o_last on the 4th, o_done one cycle later.
REQ-030 Nonzero baseline: lanes hold 100 at start, then 50 more accumulate -> each output word is 50.
REQ-031 Wrap: baseline 0xFFF0, final 0x0010 -> output 0x0020.
REQ-032 Backpressure: i_ready low for 3 cycles on word 2 -> o_data stable and o_valid high throughout; the sequence and o_last are unchanged.
REQ-033 Start during RUN is ignored; rst asserted mid-DRAIN -> outputs 0 immediately; a new job after release completes normally.
REQ-034 Back-to-back: start in the o_done cycle -> o_busy rises next cycle and the second job yields correct results.
